// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Memory-side end of the instruction fetch read interface. Holds DEPTH 32-bit
// words and serves one read request at a time. The requested word comes back
// a fixed LATENCY cycles after the request is accepted, together with a
// one-cycle read_valid pulse. mem_kick_up mirrors read_valid and starts
// decode. Misaligned or out-of-range reads return NOP_WORD with read_err set.
// A synchronous load port fills program memory in any state.
//
// Optional feature (compile-time macro INST_MEM_REQ_COUNT_EN):
//   defined   -> req_count counts accepted requests. It wraps at 2^32 and is
//                cleared by reset.
//   undefined -> no counter is built and req_count is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   read_enable  fetch requests a read (may be held high)
//   read_addr    byte address of the requested instruction
//   read_ready   a request can be accepted this cycle
//   read_valid   one-cycle pulse: read_data / read_err are valid
//   read_data    returned instruction word (held between responses)
//   read_err     response was misaligned or out of range
//   mem_kick_up  copy of read_valid, kicks decode
//   load_en      program-load write enable
//   load_addr    program-load byte address (bits [1:0] ignored, wraps)
//   load_data    program-load word
//   req_count    accepted-request counter
// -----------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [31:0] read_addr,
  output logic        read_ready,
  output logic        read_valid,
  output logic [31:0] read_data,
  output logic        read_err,
  output logic        mem_kick_up,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] req_count
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam int unsigned   CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [29:0]   DEPTH_IDX = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   snap_data;
  logic          snap_err;

  logic          accept;
  logic          req_err;
  logic [31:0]   req_word;

  // Only the low AW+2 load address bits select a word. The rest are
  // deliberately ignored so that loads wrap modulo DEPTH.
  logic          unused_load_bits;
  assign unused_load_bits = ^{load_addr[31:AW+2], load_addr[1:0]};

  assign read_ready  = (state != WAIT);
  assign accept      = read_ready && read_enable;
  assign mem_kick_up = read_valid;

  // The range test uses the full 30-bit word index. A high address must
  // never alias back into the array.
  assign req_err  = (read_addr[1:0] != 2'b00) || (read_addr[31:2] >= DEPTH_IDX);
  assign req_word = req_err ? NOP_WORD : mem[read_addr[AW+1:2]];

  // NOTE: the program memory is deliberately not reset. Clearing a RAM on reset
  // would force it into flops, and its contents must survive a fetch-side reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  // The snapshot samples req_word before this edge's load takes effect, so a
  // same-edge load to the requested word returns the old contents. A load
  // after accept cannot disturb the in-flight response.
  // NOTE: all state below uses non-blocking assignments, so every branch sees
  // pre-edge values. Blocking assignments here would race with the memory
  // write and the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      snap_data  <= '0;
      snap_err   <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      read_err   <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (read_enable) begin
            snap_data <= req_word;
            snap_err  <= req_err;
            cnt       <= CNT_INIT;
            state     <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            read_valid <= 1'b1;
            read_data  <= snap_data;
            read_err   <= snap_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INST_MEM_REQ_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_count <= '0;
    end else if (accept) begin
      req_count <= req_count + 32'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign req_count     = '0;
`endif

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder; the memory-side end of the fetch stage's read interface (read enable + 32-bit byte address).
- Holds DEPTH 32-bit words.
- Accepts one read request at a time and returns the word after a fixed LATENCY, with a one-cycle valid pulse that also serves as the kick-up to decode.
- A synchronous load port lets the bench or boot logic fill program memory.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 2.
- LATENCY, 1, cycles from request accept to response; integer >= 1.
- NOP_WORD, 32'h00000013, word returned on an erroneous access (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- read_enable  in  1  fetch requests a read; may be held high continuously.
- read_addr  in  32  byte address of the instruction.
- read_ready  out  1  request can be accepted this cycle.
- read_valid  out  1  one-cycle pulse: read_data/read_err valid.
- read_data  out  32  returned instruction word.
- read_err  out  1  qualifies read_valid: misaligned or out-of-range access.
- mem_kick_up  out  1  equals read_valid; kicks decode.
- load_en  in  1  write enable for program load.
- load_addr  in  32  byte address of the load; bits [1:0] ignored.
- load_data  in  32  word to write.
- req_count  out  32  accepted-request counter (see Optional Feature).

Behaviour:
- Reset (async) state: IDLE, read_valid=0, read_data=0, read_err=0, req_count=0, latency counter=0. Memory array is not cleared. Reset mid-request drops the request; no response is ever issued for it.
- States: IDLE, WAIT, RESP.
- read_ready=1 in IDLE and RESP, 0 in WAIT.
- Accept: on an edge where read_ready and read_enable are both 1:
  - Snapshot data = mem[read_addr[31:2]], or NOP_WORD on error.
  - Snapshot err = (read_addr[1:0]!=0) || (read_addr[31:2] >= DEPTH).
  - cnt <= LATENCY-1; state <= WAIT.
- WAIT: on each edge, if cnt==0 then state <= RESP, register read_data/read_err from the snapshot, read_valid <= 1; otherwise cnt <= cnt-1.
- Timing: request accepted at edge N gives read_valid high in the cycle following edge N+LATENCY.
- RESP: lasts exactly one cycle; read_valid <= 0 at the next edge. At that edge:
  - read_enable=1: accept the new request (back-to-back) and go to WAIT.
  - otherwise: go to IDLE.
- Throughput: one response per LATENCY+1 cycles.
- read_data and read_err hold their last response value while read_valid=0.
- Index uses read_addr[31:2]. Out-of-range is tested on the full 30-bit index, with no wrap-around.
- Load: on every edge with load_en=1, mem[load_addr[$clog2(DEPTH)+1:2]] <= load_data, in any state. Upper address bits are ignored, so a load wraps modulo DEPTH.
- Load and accept to the same word on the same edge: the read snapshot returns the OLD word.
- A load after accept does not affect the in-flight response.
- read_enable and read_addr are ignored in WAIT. The requester holds them, or re-requests after read_valid.

Optional Feature:
- Macro: INST_MEM_REQ_COUNT_EN.
- Defined: req_count increments by 1 on every accept edge, wraps 0xFFFFFFFF -> 0, and is cleared by reset.
- Undefined: no counter logic is built; req_count is tied to 0.

Test Plan:
- Load mem[0]=0x00500093, mem[1]=0x00100113; LATENCY=1; read_enable=1, read_addr=0 accepted at edge N -> read_valid=1, read_data=0x00500093, read_err=0 in the cycle after edge N+1; then addr=4 accepted at edge N+2 -> 0x00100113 after edge N+3.
- LATENCY=3; single request at addr 0x8 accepted at edge N -> read_ready=0 for 3 cycles; valid pulse of exactly one cycle after edge N+3; mem_kick_up identical to read_valid.
- read_addr=0x6 (misaligned) -> read_err=1, read_data=0x00000013. read_addr=0x400 with DEPTH=256 (index 256) -> read_err=1, read_data=0x00000013.
- Same edge: load_en=1, load_addr=0x10, load_data=0xDEADBEEF, and accept addr 0x10 with old word 0x11111111 -> response 0x11111111; next request to 0x10 -> 0xDEADBEEF.
- Assert reset while in WAIT -> read_valid stays 0, state IDLE, read_ready=1; memory contents intact (a re-read returns the loaded word).
- With INST_MEM_REQ_COUNT_EN: 5 accepted requests -> req_count=5, and reset returns it to 0. Without the macro: req_count=0 throughout.
